ps2_rx_fifo: RTL



---
 rtl/ps2_rx_fifo.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pad synchronisers, 11-bit frame decoder, byte FIFO and sticky errors.
// Optional ps2_clk glitch filter is enabled by defining PS2_RX_GLITCH_FILT_EN.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 8192
`ifdef PS2_RX_GLITCH_FILT_EN
  , parameter int FILT_LEN  = 4
`endif
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_dat_i,
  input  logic                          rd_en_i,
  input  logic                          clr_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          par_err_o,
  output logic                          frm_err_o,
  output logic                          tmo_err_o,
  output logic                          ovf_err_o,
  output logic                          irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_prev;
  logic          w_clk_cur;
  logic          w_fall;
  logic          w_dat;

  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par_ok;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_push;
  logic [7:0]    r_push_data;
  logic          r_par_set, r_frm_set, r_tmo_set;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_pop, w_full, w_wr, w_ovf_set;

  logic          r_par_err, r_frm_err, r_tmo_err, r_ovf_err;

  // Idle PS/2 bus is high, so the synchronisers reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk_i;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat_i;
      r_dat_s2 <= r_dat_s1;
    end
  end

`ifdef PS2_RX_GLITCH_FILT_EN
  localparam int FW = $clog2(FILT_LEN) + 1;
  logic          r_clk_filt;
  logic [FW-1:0] r_filt_cnt;

  // Filtered level only flips after FILT_LEN consecutive samples disagreeing with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FW'(FILT_LEN - 1)) begin
      r_clk_filt <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FW'(1);
    end
  end

  assign w_clk_cur = r_clk_filt;
`else
  assign w_clk_cur = r_clk_s2;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_clk_prev <= 1'b1;
    else       r_clk_prev <= w_clk_cur;
  end

  assign w_fall = r_clk_prev & ~w_clk_cur;
  assign w_dat  = r_dat_s2;

  // Frame decoder; push and error strobes are registered one-cycle pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_ok    <= 1'b0;
      r_tmo_cnt   <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_par_set   <= 1'b0;
      r_frm_set   <= 1'b0;
      r_tmo_set   <= 1'b0;
    end else begin
      r_push    <= 1'b0;
      r_par_set <= 1'b0;
      r_frm_set <= 1'b0;
      r_tmo_set <= 1'b0;

      if (r_state == S_IDLE || w_fall) r_tmo_cnt <= '0;
      else                             r_tmo_cnt <= r_tmo_cnt + TW'(1);

      if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            if (!w_dat) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
          S_DATA: begin
            r_shift <= {w_dat, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
            else                   r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: begin
            r_par_ok <= ^{r_shift, w_dat};
            r_state  <= S_STOP;
          end
          S_STOP: begin
            if (!w_dat) begin
              r_frm_set <= 1'b1;
            end else if (r_par_ok) begin
              r_push      <= 1'b1;
              r_push_data <= r_shift;
            end else begin
              r_par_set <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE && r_tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
        r_state   <= S_IDLE;
        r_tmo_set <= 1'b1;
      end
    end
  end

  // A push into a full FIFO still succeeds when a pop frees the head slot in the same cycle.
  assign w_pop     = rd_en_i & (r_count != '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_wr      = r_push & (~w_full | w_pop);
  assign w_ovf_set = r_push & w_full & ~w_pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr] <= r_push_data;
  end

  // Sticky flags: a new set wins over a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_tmo_err <= 1'b0;
      r_ovf_err <= 1'b0;
    end else begin
      if (r_par_set)  r_par_err <= 1'b1;
      else if (clr_i) r_par_err <= 1'b0;
      if (r_frm_set)  r_frm_err <= 1'b1;
      else if (clr_i) r_frm_err <= 1'b0;
      if (r_tmo_set)  r_tmo_err <= 1'b1;
      else if (clr_i) r_tmo_err <= 1'b0;
      if (w_ovf_set)  r_ovf_err <= 1'b1;
      else if (clr_i) r_ovf_err <= 1'b0;
    end
  end

  assign valid_o   = (r_count != '0);
  assign data_o    = valid_o ? r_mem[r_rptr] : 8'h00;
  assign count_o   = r_count;
  assign par_err_o = r_par_err;
  assign frm_err_o = r_frm_err;
  assign tmo_err_o = r_tmo_err;
  assign ovf_err_o = r_ovf_err;
  assign irq_o     = valid_o | r_par_err | r_frm_err | r_tmo_err | r_ovf_err;

endmodule
